// File: rtl/disp_scan_arbiter.sv
// -----------------------------------------------------------------------------
// disp_scan_arbiter
//
// Purpose:
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display, combined with a two-requester ownership arbiter. Ownership can
//   change only at frame boundaries. The winner's value, decimal points and
//   blanking are captured into a snapshot at that boundary, so a frame never
//   shows a mix of old and new data.
//
// Ports:
//   mclk            system clock; all logic is on the rising edge
//   rst             synchronous, active-high reset
//   req0 / req1     level requests for display ownership (req1 has priority)
//   val0 / val1     four hex nibbles; [3:0] is digit 0 (rightmost, an[0])
//   dp0 / dp1       per-digit decimal point, 1 = lit
//   blank0 / blank1 per-digit blank, 1 = anode held off
//   gnt             one-hot current owner {OWN1, OWN0}; 00 = idle
//   frame           one-cycle pulse following each frame-end edge
//   seg             active-low segments, seg[0]=a .. seg[6]=g
//   dp              active-low decimal point
//   an              active-low anodes
//   dbg_state       current arbiter state (IDLE=0, OWN0=1, OWN1=2)
// -----------------------------------------------------------------------------
module disp_scan_arbiter #(
   parameter int PRESCALE = 50000
) (
   input  logic        mclk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [15:0] val0,
   input  logic [15:0] val1,
   input  logic [3:0]  dp0,
   input  logic [3:0]  dp1,
   input  logic [3:0]  blank0,
   input  logic [3:0]  blank1,
   output logic [1:0]  gnt,
   output logic        frame,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic [1:0]  dbg_state
);

   localparam int            PW   = $clog2(PRESCALE);
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   logic [PW-1:0] r_pcnt;
   logic [1:0]    r_digit;
   state_t        r_state;
   logic [15:0]   r_snap_val;
   logic [3:0]    r_snap_dp;
   logic [3:0]    r_snap_blank;

   logic          w_tick;
   logic          w_frame_end;
   state_t        w_state_nxt;
   logic [1:0]    w_digit_nxt;
   logic [15:0]   w_val_nxt;
   logic [3:0]    w_dpm_nxt;
   logic [3:0]    w_blank_nxt;
   logic [3:0]    w_nib;
   logic [6:0]    w_seg_hex;
   logic [6:0]    w_seg_nxt;
   logic          w_dp_nxt;
   logic [3:0]    w_an_nxt;

   assign w_tick      = (r_pcnt == PMAX);
   assign w_frame_end = w_tick && (r_digit == 2'd3);
   assign w_digit_nxt = w_frame_end ? 2'd0 : r_digit + 2'd1;
   assign dbg_state   = r_state;

   // Next-state and snapshot selection. Everything holds between frame ends;
   // at a frame end req1 wins over req0, and the winner's inputs are captured.
   always_comb begin
      w_state_nxt = r_state;
      w_val_nxt   = r_snap_val;
      w_dpm_nxt   = r_snap_dp;
      w_blank_nxt = r_snap_blank;
      if (w_frame_end) begin
         if (req1) begin
            w_state_nxt = ST_OWN1;
            w_val_nxt   = val1;
            w_dpm_nxt   = dp1;
            w_blank_nxt = blank1;
         end else if (req0) begin
            w_state_nxt = ST_OWN0;
            w_val_nxt   = val0;
            w_dpm_nxt   = dp0;
            w_blank_nxt = blank0;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end
   end

   // Decode for the digit about to be shown. Using the next state/snapshot
   // lets digit 0 of a new frame appear on the same edge as the new grant.
   always_comb begin
      w_nib = w_val_nxt[{w_digit_nxt, 2'b00} +: 4];
      case (w_nib)
         4'h0:    w_seg_hex = 7'h40;
         4'h1:    w_seg_hex = 7'h79;
         4'h2:    w_seg_hex = 7'h24;
         4'h3:    w_seg_hex = 7'h30;
         4'h4:    w_seg_hex = 7'h19;
         4'h5:    w_seg_hex = 7'h12;
         4'h6:    w_seg_hex = 7'h02;
         4'h7:    w_seg_hex = 7'h78;
         4'h8:    w_seg_hex = 7'h00;
         4'h9:    w_seg_hex = 7'h10;
         4'hA:    w_seg_hex = 7'h08;
         4'hB:    w_seg_hex = 7'h03;
         4'hC:    w_seg_hex = 7'h46;
         4'hD:    w_seg_hex = 7'h21;
         4'hE:    w_seg_hex = 7'h06;
         default: w_seg_hex = 7'h0E;
      endcase
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
      w_an_nxt  = 4'b1111;
      if ((w_state_nxt != ST_IDLE) && !w_blank_nxt[w_digit_nxt]) begin
         w_seg_nxt = w_seg_hex;
         w_dp_nxt  = ~w_dpm_nxt[w_digit_nxt];
         w_an_nxt  = ~(4'b0001 << w_digit_nxt);
      end
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         r_pcnt       <= '0;
         r_digit      <= 2'd0;
         r_state      <= ST_IDLE;
         r_snap_val   <= '0;
         r_snap_dp    <= '0;
         r_snap_blank <= '0;
         gnt          <= 2'b00;
         frame        <= 1'b0;
         seg          <= 7'h7F;
         dp           <= 1'b1;
         an           <= 4'b1111;
      end else begin
         r_pcnt       <= w_tick ? '0 : r_pcnt + PW'(1);
         r_state      <= w_state_nxt;
         r_snap_val   <= w_val_nxt;
         r_snap_dp    <= w_dpm_nxt;
         r_snap_blank <= w_blank_nxt;
         frame        <= w_frame_end;
         gnt          <= {w_state_nxt == ST_OWN1, w_state_nxt == ST_OWN0};
         if (w_tick) begin
            r_digit <= w_digit_nxt;
            seg     <= w_seg_nxt;
            dp      <= w_dp_nxt;
            an      <= w_an_nxt;
         end
      end
   end

endmodule

// File: tb/tb_disp_scan_arbiter.sv
module tb_disp_scan_arbiter;

   localparam int P = 4;

   logic        mclk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [15:0] val0 = '0, val1 = '0;
   logic [3:0]  dp0 = '0, dp1 = '0, blank0 = '0, blank1 = '0;
   logic [1:0]  gnt;
   logic        frame;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   disp_scan_arbiter #(.PRESCALE(P)) dut (
      .mclk(mclk), .rst(rst), .req0(req0), .req1(req1),
      .val0(val0), .val1(val1), .dp0(dp0), .dp1(dp1),
      .blank0(blank0), .blank1(blank1),
      .gnt(gnt), .frame(frame), .seg(seg), .dp(dp), .an(an),
      .dbg_state(dbg_state)
   );

   // clock
   always #5 mclk = ~mclk;

   // watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   // hex segment table (active low, seg[6:0])
   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      logic        r0, r1;
      logic [15:0] v0, v1;
      logic [3:0]  d0, d1, b0, b1;
      logic [1:0]  e_gnt;
      logic [15:0] e_an;   // {slot3, slot2, slot1, slot0}
      logic [27:0] e_seg;  // {slot3, slot2, slot1, slot0}
      logic [3:0]  e_dp;   // bit s = dp in slot s
   } vec_t;

   vec_t tv [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) @(posedge mclk);
      #1;
   endtask

   task automatic check_slot(input string nm, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp);
      chk({nm, "_an"}, 32'(an), 32'(e_an));
      chk({nm, "_seg"}, 32'(seg), 32'(e_seg));
      chk({nm, "_dp"}, 32'(dp), 32'(e_dp));
   endtask

   // Bounded wait for the frame pulse; leaves time #1 after the frame_end edge.
   task automatic wait_frame(input string nm);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 8 * P + 4; i++) begin
         @(posedge mclk);
         #1;
         if (frame) begin
            got = 1'b1;
            break;
         end
      end
      chk({nm, "_frame_wait"}, 32'(got), 32'd1);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_gnt"}, 32'(gnt), 32'd0);
      chk({nm, "_frame"}, 32'(frame), 32'd0);
      check_slot(nm, 4'b1111, 7'h7F, 1'b1);
   endtask

   // reference model state for the random phase
   int          m_k;
   int          m_own;
   logic [15:0] m_v;
   logic [3:0]  m_d, m_b;

   initial begin
      logic [1:0] e_gnt;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp, e_frame;
      int         dg;

      tv[0] = '{1'b1, 1'b0, 16'h8F10, 16'h0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000,
                2'b01, 16'h7BDE, {7'h00, 7'h0E, 7'h79, 7'h40}, 4'b1011};
      tv[1] = '{1'b1, 1'b1, 16'h8F10, 16'h0000, 4'b0100, 4'b0000, 4'b0000, 4'b1010,
                2'b10, 16'hFBFE, {7'h7F, 7'h40, 7'h7F, 7'h40}, 4'b1111};
      tv[2] = '{1'b0, 1'b0, 16'h1234, 16'h5678, 4'b1111, 4'b1111, 4'b0000, 4'b0000,
                2'b00, 16'hFFFF, {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111};
      tv[3] = '{1'b1, 1'b0, 16'h3C2A, 16'hFFFF, 4'b1001, 4'b0000, 4'b0100, 4'b0000,
                2'b01, 16'h7FDE, {7'h30, 7'h7F, 7'h24, 7'h08}, 4'b0110};
      tv[4] = '{1'b0, 1'b1, 16'h0000, 16'h7E5B, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                2'b10, 16'h7BDE, {7'h78, 7'h06, 7'h12, 7'h03}, 4'b1111};
      tv[5] = '{1'b1, 1'b1, 16'h1111, 16'hD946, 4'b0000, 4'b0010, 4'b0000, 4'b0001,
                2'b10, 16'h7BDF, {7'h21, 7'h10, 7'h19, 7'h7F}, 4'b1101};

      // ---------------- reset ----------------
      rst = 1'b1;
      tick_n(3);
      check_reset_vals("reset");
      rst = 1'b0;
      tick_n(4 * P - 1);
      chk("first_frame_early", 32'(frame), 32'd0);
      tick_n(1);
      chk("first_frame", 32'(frame), 32'd1);
      chk("first_frame_gnt", 32'(gnt), 32'd0);

      // ---------------- table-driven frames ----------------
      for (int t = 0; t < 6; t++) begin
         req0 = tv[t].r0; req1 = tv[t].r1;
         val0 = tv[t].v0; val1 = tv[t].v1;
         dp0 = tv[t].d0; dp1 = tv[t].d1;
         blank0 = tv[t].b0; blank1 = tv[t].b1;
         wait_frame($sformatf("tv%0d", t));
         chk($sformatf("tv%0d_gnt", t), 32'(gnt), 32'(tv[t].e_gnt));
         check_slot($sformatf("tv%0d_s0", t), tv[t].e_an[3:0], tv[t].e_seg[6:0], tv[t].e_dp[0]);
         tick_n(1);
         chk($sformatf("tv%0d_frame_one_cycle", t), 32'(frame), 32'd0);
         tick_n(P - 1);
         for (int s = 1; s < 4; s++) begin
            if (s > 1) tick_n(P);
            check_slot($sformatf("tv%0d_s%0d", t, s), tv[t].e_an[s*4 +: 4],
                       tv[t].e_seg[s*7 +: 7], tv[t].e_dp[s]);
         end
      end

      // ---------------- preemption and tear-freedom ----------------
      req1 = 1'b0; req0 = 1'b1;
      val0 = 16'h8F10; dp0 = 4'b0100; blank0 = 4'b0000;
      wait_frame("tear_start");
      chk("tear_gnt0", 32'(gnt), 32'd1);
      check_slot("tear_s0", 4'b1110, 7'h40, 1'b1);
      tick_n(1);
      val0 = 16'hFFFF; req1 = 1'b1; val1 = 16'h0000; dp1 = 4'b0000; blank1 = 4'b0000;
      tick_n(P - 1);
      check_slot("tear_s1", 4'b1101, 7'h79, 1'b1);
      tick_n(P);
      check_slot("tear_s2", 4'b1011, 7'h0E, 1'b0);
      tick_n(P);
      check_slot("tear_s3", 4'b0111, 7'h00, 1'b1);
      tick_n(P - 1);
      chk("tear_gnt_before_end", 32'(gnt), 32'd1);
      tick_n(1);
      chk("preempt_frame", 32'(frame), 32'd1);
      chk("preempt_gnt", 32'(gnt), 32'd2);
      check_slot("preempt_s0", 4'b1110, 7'h40, 1'b1);

      // ---------------- release and idle ----------------
      tick_n(1);
      req1 = 1'b0; req0 = 1'b0;
      tick_n(P - 1);
      chk("rel_hold_s1_gnt", 32'(gnt), 32'd2);
      check_slot("rel_hold_s1", 4'b1101, 7'h40, 1'b1);
      tick_n(2 * P);
      chk("rel_hold_s3_gnt", 32'(gnt), 32'd2);
      check_slot("rel_hold_s3", 4'b0111, 7'h40, 1'b1);
      tick_n(P);
      chk("rel_frame", 32'(frame), 32'd1);
      chk("rel_idle_gnt", 32'(gnt), 32'd0);
      check_slot("rel_idle", 4'b1111, 7'h7F, 1'b1);
      tick_n(1);
      req0 = 1'b1;
      tick_n(4 * P - 2);
      chk("regrant_wait_gnt", 32'(gnt), 32'd0);
      tick_n(1);
      chk("regrant_frame", 32'(frame), 32'd1);
      chk("regrant_gnt", 32'(gnt), 32'd1);
      check_slot("regrant_s0", 4'b1110, 7'h0E, 1'b1);

      // ---------------- reset mid-operation (digit 2, tick pending) ----------------
      tick_n(3 * P - 1);
      rst = 1'b1;
      tick_n(1);
      check_reset_vals("midrst");
      rst = 1'b0;
      tick_n(P);
      check_slot("midrst_after_tick", 4'b1111, 7'h7F, 1'b1);
      tick_n(3 * P - 1);
      chk("midrst_frame_early", 32'(frame), 32'd0);
      chk("midrst_gnt_idle", 32'(gnt), 32'd0);
      tick_n(1);
      chk("midrst_frame", 32'(frame), 32'd1);
      chk("midrst_gnt", 32'(gnt), 32'd1);
      check_slot("midrst_s0", 4'b1110, 7'h0E, 1'b1);

      // ---------------- randomized against reference model ----------------
      for (int c = 0; c < 1600; c++) begin
         rst = (c == 0) || ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 19) == 0) req0 = ~req0;
         if ($urandom_range(0, 29) == 0) req1 = ~req1;
         val0 = 16'($urandom); val1 = 16'($urandom);
         dp0 = 4'($urandom); dp1 = 4'($urandom);
         blank0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         blank1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         @(posedge mclk);
         if (rst) begin
            m_k = 0; m_own = 0; m_v = '0; m_d = '0; m_b = '0;
            e_frame = 1'b0;
         end else begin
            m_k++;
            e_frame = (m_k % (4 * P)) == 0;
            if (e_frame) begin
               if (req1) begin
                  m_own = 2; m_v = val1; m_d = dp1; m_b = blank1;
               end else if (req0) begin
                  m_own = 1; m_v = val0; m_d = dp0; m_b = blank0;
               end else begin
                  m_own = 0;
               end
            end
         end
         dg = (m_k / P) % 4;
         e_gnt = (m_own == 2) ? 2'b10 : (m_own == 1) ? 2'b01 : 2'b00;
         if (m_own == 0 || m_b[dg]) begin
            e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
         end else begin
            e_an = ~(4'b0001 << dg);
            e_seg = hex_tab[m_v[dg*4 +: 4]];
            e_dp = ~m_d[dg];
         end
         #1;
         chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
         chk("rnd_frame", 32'(frame), 32'(e_frame));
         chk("rnd_an", 32'(an), 32'(e_an));
         chk("rnd_seg", 32'(seg), 32'(e_seg));
         chk("rnd_dp", 32'(dp), 32'(e_dp));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
